// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_resp
// Brief    : Byte-writable word memory with a fixed-latency request/response
//            handshake, address range checking and lane-enable validation.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_resp #(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_Req,
    input  logic        Mem_We,
    input  logic [31:0] Mem_Addr,
    input  logic [3:0]  Data_Mem_Write_Ctrl,
    input  logic [31:0] Data_Mem_Write,
    output logic        Mem_Ready,
    output logic        Mem_Resp_Valid,
    output logic [31:0] Data_Mem_Read,
    output logic        Mem_Err
);

    localparam int         c_DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [1:0] c_CNT_INIT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [1:0]              r_cnt;

    logic                    r_we;
    logic [31:2]             r_addr;
    logic [3:0]              r_ctrl;
    logic [31:0]             r_wdata;

    logic [31:0]             r_mem [c_DEPTH];
    logic [31:0]             r_rdata;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_tx_we;
    logic [31:2]             w_tx_addr;
    logic [3:0]              w_tx_ctrl;
    logic [31:0]             w_tx_wdata;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic                    w_oor;
    logic                    w_err;
    logic                    w_enter_resp;
    logic [3:0]              w_we_lanes;
    logic [31:0]             w_old_word;
    logic [31:0]             w_merged;
    logic                    w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^Mem_Addr[1:0];

    assign w_accept = Mem_Req & (r_state == ST_IDLE);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (READ_LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // With a one-cycle latency the commit edge is the acceptance edge, so the
    // live inputs are used while idle and the captured copy afterwards.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_tx_we    = Mem_We;
            w_tx_addr  = Mem_Addr[31:2];
            w_tx_ctrl  = Data_Mem_Write_Ctrl;
            w_tx_wdata = Data_Mem_Write;
        end else begin
            w_tx_we    = r_we;
            w_tx_addr  = r_addr;
            w_tx_ctrl  = r_ctrl;
            w_tx_wdata = r_wdata;
        end
    end

    assign w_idx        = w_tx_addr[ADDR_WIDTH+1:2];
    assign w_oor        = |w_tx_addr[31:ADDR_WIDTH+2];
    assign w_err        = w_oor | (w_tx_we & (w_tx_ctrl == 4'b0000));
    assign w_enter_resp = (w_next_state == ST_RESP) & (r_state != ST_RESP) & ~Reset;
    assign w_we_lanes   = (w_enter_resp & w_tx_we & ~w_err) ? w_tx_ctrl : 4'b0000;
    assign w_old_word   = r_mem[w_idx];

    // Response word reflects the post-write content, so loads after stores never see stale bytes.
    always_comb begin
        w_merged = w_old_word;
        for (int i = 0; i < 4; i++) begin
            if (w_we_lanes[i]) begin
                w_merged[8*i +: 8] = w_tx_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cnt <= c_CNT_INIT;
            end else if ((r_state == ST_WAIT) && (r_cnt != 2'd0)) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if (w_enter_resp) begin
                r_rdata <= w_oor ? 32'h0 : w_merged;
                r_err   <= w_err;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_we    <= Mem_We;
            r_addr  <= Mem_Addr[31:2];
            r_ctrl  <= Data_Mem_Write_Ctrl;
            r_wdata <= Data_Mem_Write;
        end
    end

    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_we_lanes[i]) begin
                r_mem[w_idx][8*i +: 8] <= w_tx_wdata[8*i +: 8];
            end
        end
    end

    assign Mem_Ready      = (r_state == ST_IDLE);
    assign Mem_Resp_Valid = (r_state == ST_RESP);
    assign Data_Mem_Read  = r_rdata;
    assign Mem_Err        = r_err;

endmodule
`default_nettype wire
